axi_write_vector: RTL and testbench

AXI_WRITE_VECTOR -- requirements
Module: axi_write_vector

---
 rtl/axi_write_vector_pkg.sv | 21 ++
 rtl/axi_write_vector_if.sv | 20 ++
 rtl/axi_write_vector.sv | 108 ++++++++++
 tb/tb_axi_write_vector.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/axi_write_vector_pkg.sv
// ------------------------------------------------------------------
// axi_vector_pkg : FSM states and chunk math shared by vector blocks. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package axi_vector_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } vec_state_t;

  // ceil(len / w) for len >= 0, w >= 1
  function automatic int chunk_count(input int len, input int w);
    return (len + w - 1) / w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi_write_vector_if.sv
// ------------------------------------------------------------------
// axi_stream_if : minimal AXI-Stream bundle (tdata/tvalid/tlast/tready). Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface axi_stream_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

`default_nettype wire

// File: rtl/axi_write_vector.sv
// ------------------------------------------------------------------
// axi_write_vector : serialises a captured bit vector into AXI-Stream beats. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module axi_write_vector
  import axi_vector_pkg::*;
#(
  parameter int MAX_VEC_LENGTH = 64,
  parameter int AXI_DATA_WIDTH = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [$clog2(MAX_VEC_LENGTH+1)-1:0] vec_length,
  input  logic [MAX_VEC_LENGTH-1:0]           vec,
  axi_stream_if.master                        data_out,
  output logic                                busy,
  output logic                                done
);

  localparam int LEN_W      = $clog2(MAX_VEC_LENGTH + 1);
  localparam int W          = AXI_DATA_WIDTH;
  localparam int MAX_CHUNKS = chunk_count(MAX_VEC_LENGTH, W);
  localparam int CNT_W      = (MAX_CHUNKS > 1) ? $clog2(MAX_CHUNKS) : 1;
  localparam int PAD_W      = MAX_CHUNKS * W;

  vec_state_t       state;
  logic [PAD_W-1:0] vec_reg;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] last_idx;
  logic [CNT_W-1:0] next_cnt;
  logic [LEN_W-1:0] len_clamped;
  logic [PAD_W-1:0] vec_masked;
  int               n_beats;
  logic             handshake;

  // Bits at or above the clamped length are zeroed once at capture time,
  // so every later beat is a plain slice of vec_reg.
  always_comb begin
    len_clamped = (int'(vec_length) > MAX_VEC_LENGTH) ? LEN_W'(MAX_VEC_LENGTH) : vec_length;
    vec_masked  = '0;
    for (int i = 0; i < MAX_VEC_LENGTH; i++) begin
      vec_masked[i] = vec[i] & (i < int'(len_clamped));
    end
    n_beats   = chunk_count(int'(len_clamped), W);
    next_cnt  = beat_cnt + 1'b1;
    handshake = data_out.tvalid && data_out.tready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      vec_reg         <= '0;
      beat_cnt        <= '0;
      last_idx        <= '0;
      data_out.tdata  <= '0;
      data_out.tvalid <= 1'b0;
      data_out.tlast  <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            vec_reg  <= vec_masked;
            last_idx <= CNT_W'(n_beats - 1);
            beat_cnt <= '0;
            busy     <= 1'b1;
            if (len_clamped == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state           <= SEND;
              data_out.tvalid <= 1'b1;
              data_out.tdata  <= vec_masked[W-1:0];
              data_out.tlast  <= (n_beats == 1);
            end
          end
        end
        SEND: begin
          if (handshake) begin
            if (beat_cnt == last_idx) begin
              state           <= DONE;
              data_out.tvalid <= 1'b0;
              data_out.tlast  <= 1'b0;
              data_out.tdata  <= '0;
              done            <= 1'b1;
            end else begin
              beat_cnt       <= next_cnt;
              data_out.tdata <= vec_reg[int'(next_cnt)*W +: W];
              data_out.tlast <= (next_cnt == last_idx);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_write_vector.sv
// ------------------------------------------------------------------
// tb_axi_write_vector : directed bench for axi_write_vector (W=8, MAX=20). Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_axi_write_vector;

  localparam int W   = 8;
  localparam int MAX = 20;
  localparam int LW  = 5;

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b0;
  logic          start      = 1'b0;
  logic [LW-1:0] vec_length = '0;
  logic [MAX-1:0] vec       = '0;
  logic          busy;
  logic          done;

  axi_stream_if #(.DATA_WIDTH(W)) axis ();

  axi_write_vector #(
    .MAX_VEC_LENGTH(MAX),
    .AXI_DATA_WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .vec_length (vec_length),
    .vec        (vec),
    .data_out   (axis),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int       n_checks = 0;
  int       n_pass   = 0;
  logic [7:0] exp_beats [0:3];
  int       exp_n;
  bit       pat [0:3] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input int n);
    exp_beats[0] = b0;
    exp_beats[1] = b1;
    exp_beats[2] = b2;
    exp_beats[3] = 8'h00;
    exp_n        = n;
  endtask

  task automatic kick(input logic [MAX-1:0] v, input logic [LW-1:0] l);
    axis.tready = 1'b1;
    vec         = v;
    vec_length  = l;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  // Tracks the expected beat index; a stalled beat must reappear unchanged.
  task automatic run_xfer(input bit stall, input bit meddle);
    int idx  = 0;
    bit seen = 1'b0;
    check("first_tvalid", axis.tvalid, 1);
    for (int c = 0; c < 40 && !seen; c++) begin
      axis.tready = stall ? pat[c % 4] : 1'b1;
      start       = meddle && (c == 1);
      if (meddle && c == 1) begin
        vec        = 20'h12345;
        vec_length = 5'd8;
      end
      if (axis.tvalid) begin
        if (idx >= exp_n) begin
          check("extra_beat", idx, exp_n);
        end else begin
          check("beat_data", axis.tdata, exp_beats[idx]);
          check("beat_last", axis.tlast, (idx == exp_n - 1));
        end
        if (axis.tready) idx++;
      end
      if (done) begin
        seen = 1'b1;
        check("beat_count", idx, exp_n);
        check("done_tvalid", axis.tvalid, 0);
        check("done_busy", busy, 1);
      end
      tick();
    end
    start = 1'b0;
    if (!seen) begin
      check("done_timeout", 0, 1);
    end else begin
      check("done_one_cycle", done, 0);
      check("busy_cleared", busy, 0);
    end
  endtask

  initial begin
    axis.tready = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_tvalid", axis.tvalid, 0);
    check("rst_tlast", axis.tlast, 0);
    check("rst_tdata", axis.tdata, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    set_exp(8'hDE, 8'hBC, 8'h0A, 3);
    kick(20'hABCDE, 5'd20);
    run_xfer(1'b0, 1'b0);

    set_exp(8'hFF, 8'h0F, 8'h00, 2);
    kick(20'hFFFFF, 5'd12);
    run_xfer(1'b0, 1'b0);

    set_exp(8'hDE, 8'hBC, 8'h0A, 3);
    kick(20'hABCDE, 5'd20);
    run_xfer(1'b1, 1'b0);

    // length above MAX clamps to 20 bits
    set_exp(8'hFF, 8'hFF, 8'h0F, 3);
    kick(20'hFFFFF, 5'd31);
    run_xfer(1'b0, 1'b0);

    kick(20'hFFFFF, 5'd0);
    check("len0_done", done, 1);
    check("len0_tvalid", axis.tvalid, 0);
    check("len0_busy", busy, 1);
    tick();
    check("len0_done_clr", done, 0);
    check("len0_busy_clr", busy, 0);
    check("len0_tvalid_idle", axis.tvalid, 0);
    tick();

    set_exp(8'hDE, 8'hBC, 8'h0A, 3);
    kick(20'hABCDE, 5'd20);
    run_xfer(1'b0, 1'b1);
    set_exp(8'h5C, 8'h0A, 8'h00, 2);
    kick(20'h00A5C, 5'd12);
    run_xfer(1'b0, 1'b0);
    tick();

    kick(20'hABCDE, 5'd20);
    check("pre_rst_beat0", axis.tdata, 8'hDE);
    tick();
    check("pre_rst_beat1", axis.tdata, 8'hBC);
    rst_n = 1'b0;
    tick();
    check("mid_rst_tvalid", axis.tvalid, 0);
    check("mid_rst_tdata", axis.tdata, 0);
    check("mid_rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_tvalid", axis.tvalid, 0);
    set_exp(8'h5A, 8'h00, 8'h00, 1);
    kick(20'h0005A, 5'd8);
    run_xfer(1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
